// File: rtl/simplez_ctrl.sv
// Simplez sequencer: fetch/decode/operand/writeback FSM driving the
// datapath microorders, plus halt/resume and an instruction counter.
module simplez_ctrl #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      co,
    input  logic            z,
    input  logic            cont,
    output logic            lec,
    output logic            esc,
    output logic            era,
    output logic            incp,
    output logic            ecp,
    output logic            ccp,
    output logic            scp,
    output logic            eri,
    output logic            sri,
    output logic            eac,
    output logic            sac,
    output logic [1:0]      alu,
    output logic            stop,
    output logic [CNTW-1:0] ninstr
);

    typedef enum logic [2:0] {
        S_RST0,
        S_I0,
        S_I1,
        S_O0,
        S_O1,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_ST  = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_BR  = 3'd3;
    localparam logic [2:0] OP_BZ  = 3'd4;
    localparam logic [2:0] OP_CLR = 3'd5;
    localparam logic [2:0] OP_DEC = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_DEC  = 2'b10;
    localparam logic [1:0] ALU_ZERO = 2'b11;

    state_t state;
    state_t nxt;

    // The datapath registers update on the falling edge, so does the sequencer
    always_ff @(negedge clk) begin
        if (rst) begin
            state <= S_RST0;
        end else begin
            state <= nxt;
        end
    end

    // Leaving RST0 into I0 is not a completed instruction
    always_ff @(negedge clk) begin
        if (rst) begin
            ninstr <= '0;
        end else if (nxt == S_I0 && state != S_RST0) begin
            ninstr <= ninstr + CNTW'(1);
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_RST0: nxt = S_I0;
            S_I0:   nxt = S_I1;
            S_I1: begin
                unique case (co)
                    OP_ST, OP_LD, OP_ADD: nxt = S_O0;
                    OP_HLT:               nxt = S_HALT;
                    default:              nxt = S_I0;
                endcase
            end
            S_O0:   nxt = S_O1;
            S_O1:   nxt = S_I0;
            S_HALT: nxt = cont ? S_I0 : S_HALT;
            default: nxt = S_RST0;
        endcase
    end

    always_comb begin
        lec  = 1'b0;
        esc  = 1'b0;
        era  = 1'b0;
        incp = 1'b0;
        ecp  = 1'b0;
        ccp  = 1'b0;
        scp  = 1'b0;
        eri  = 1'b0;
        sri  = 1'b0;
        eac  = 1'b0;
        sac  = 1'b0;
        alu  = ALU_PASS;
        stop = 1'b0;
        unique case (state)
            S_RST0: begin
                ccp = 1'b1;
                era = 1'b1;
                scp = 1'b1;
            end
            S_I0: begin
                lec  = 1'b1;
                eri  = 1'b1;
                incp = 1'b1;
            end
            S_I1: begin
                unique case (co)
                    OP_ST, OP_LD, OP_ADD: begin
                        sri = 1'b1;
                        era = 1'b1;
                    end
                    OP_BR: begin
                        sri = 1'b1;
                        era = 1'b1;
                        ecp = 1'b1;
                    end
                    OP_BZ: begin
                        era = 1'b1;
                        sri = z;
                        ecp = z;
                        scp = ~z;
                    end
                    OP_CLR: begin
                        eac = 1'b1;
                        alu = ALU_ZERO;
                        scp = 1'b1;
                        era = 1'b1;
                    end
                    OP_DEC: begin
                        eac = 1'b1;
                        alu = ALU_DEC;
                        scp = 1'b1;
                        era = 1'b1;
                    end
                    default: begin
                        scp = 1'b1;
                        era = 1'b1;
                    end
                endcase
            end
            S_O0: begin
                unique case (co)
                    OP_ST: begin
                        sac = 1'b1;
                        esc = 1'b1;
                    end
                    OP_LD: begin
                        lec = 1'b1;
                        eac = 1'b1;
                    end
                    OP_ADD: begin
                        lec = 1'b1;
                        eac = 1'b1;
                        alu = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_O1: begin
                scp = 1'b1;
                era = 1'b1;
            end
            S_HALT: stop = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simplez_ctrl.sv
// Bench for simplez_ctrl: directed scenarios then random opcode streams,
// checked against an instruction-level cycle model of the sequencer.
module tb_simplez_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  co;
    logic        z;
    logic        cont;
    logic        lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac;
    logic [1:0]  alu;
    logic        stop;
    logic [15:0] ninstr;
    logic        w_lec, w_esc, w_era, w_incp, w_ecp, w_ccp, w_scp;
    logic        w_eri, w_sri, w_eac, w_sac, w_stop;
    logic [1:0]  w_alu;
    logic [3:0]  nw;

    int checks = 0;
    int failures = 0;

    // Model: reset stub, halted flag, cycle index inside the instruction
    bit          m_rst;
    bit          m_halt;
    int          m_cyc;
    int          m_cnt;
    logic [2:0]  op_sel;

    simplez_ctrl #(.CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .co(co), .z(z), .cont(cont),
        .lec(lec), .esc(esc), .era(era), .incp(incp), .ecp(ecp),
        .ccp(ccp), .scp(scp), .eri(eri), .sri(sri), .eac(eac),
        .sac(sac), .alu(alu), .stop(stop), .ninstr(ninstr)
    );

    simplez_ctrl #(.CNTW(4)) u_w (
        .clk(clk), .rst(rst), .co(co), .z(z), .cont(cont),
        .lec(w_lec), .esc(w_esc), .era(w_era), .incp(w_incp),
        .ecp(w_ecp), .ccp(w_ccp), .scp(w_scp), .eri(w_eri),
        .sri(w_sri), .eac(w_eac), .sac(w_sac), .alu(w_alu),
        .stop(w_stop), .ninstr(nw)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // {lec,esc,era,incp,ecp,ccp,scp,eri,sri,eac,sac,alu,stop}
    function automatic logic [13:0] exp_out(input bit r, input bit h,
                                            input int cyc,
                                            input logic [2:0] c,
                                            input logic zz);
        logic l_lec, l_esc, l_era, l_incp, l_ecp, l_ccp, l_scp;
        logic l_eri, l_sri, l_eac, l_sac, l_stop;
        logic [1:0] l_alu;
        {l_lec, l_esc, l_era, l_incp, l_ecp, l_ccp, l_scp} = '0;
        {l_eri, l_sri, l_eac, l_sac, l_stop} = '0;
        l_alu = 2'b00;
        if (r) begin
            l_ccp = 1; l_era = 1; l_scp = 1;
        end else if (h) begin
            l_stop = 1;
        end else if (cyc == 0) begin
            l_lec = 1; l_eri = 1; l_incp = 1;
        end else if (cyc == 1) begin
            if (c < 3) begin
                l_sri = 1; l_era = 1;
            end else if (c == 3 || (c == 4 && zz)) begin
                l_sri = 1; l_era = 1; l_ecp = 1;
            end else if (c == 4) begin
                l_scp = 1; l_era = 1;
            end else if (c == 5) begin
                l_eac = 1; l_alu = 2'b11; l_scp = 1; l_era = 1;
            end else if (c == 6) begin
                l_eac = 1; l_alu = 2'b10; l_scp = 1; l_era = 1;
            end else begin
                l_scp = 1; l_era = 1;
            end
        end else if (cyc == 2) begin
            if (c == 0) begin
                l_sac = 1; l_esc = 1;
            end else if (c == 1) begin
                l_lec = 1; l_eac = 1;
            end else if (c == 2) begin
                l_lec = 1; l_eac = 1; l_alu = 2'b01;
            end
        end else begin
            l_scp = 1; l_era = 1;
        end
        return {l_lec, l_esc, l_era, l_incp, l_ecp, l_ccp, l_scp,
                l_eri, l_sri, l_eac, l_sac, l_alu, l_stop};
    endfunction

    task automatic cycle(input logic r, input logic cv, input logic zv);
        logic [13:0] obs;
        logic [13:0] obs_w;
        if (!m_rst && !m_halt && m_cyc == 0) co = op_sel;
        rst = r;
        cont = cv;
        z = zv;
        @(posedge clk);
        obs = {lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac,
               alu, stop};
        obs_w = {w_lec, w_esc, w_era, w_incp, w_ecp, w_ccp, w_scp,
                 w_eri, w_sri, w_eac, w_sac, w_alu, w_stop};
        chk("uorders", 32'(obs), 32'(exp_out(m_rst, m_halt, m_cyc, co, z)));
        chk("uorders_w", 32'(obs_w), 32'(obs));
        chk("ninstr", 32'(ninstr), 32'(m_cnt % 65536));
        chk("ninstr_w", 32'(nw), 32'(m_cnt % 16));
        @(negedge clk);
        if (r) begin
            m_rst = 1; m_halt = 0; m_cyc = 0; m_cnt = 0;
        end else if (m_rst) begin
            m_rst = 0; m_cyc = 0;
        end else if (m_halt) begin
            if (cv) begin
                m_halt = 0; m_cyc = 0; m_cnt++;
            end
        end else if (m_cyc == 0) begin
            m_cyc = 1;
        end else if (m_cyc == 1) begin
            if (co == 7) m_halt = 1;
            else if (co < 3) m_cyc = 2;
            else begin
                m_cyc = 0; m_cnt++;
            end
        end else if (m_cyc == 2) begin
            m_cyc = 3;
        end else begin
            m_cyc = 0; m_cnt++;
        end
        #1;
    endtask

    // Starts at I0; checks the spec latency back to the next I0
    task automatic run_instr(input logic [2:0] op, input logic zv,
                             input logic cv);
        int n;
        n = 0;
        op_sel = op;
        do begin
            cycle(1'b0, cv, zv);
            n++;
        end while (!(m_cyc == 0 && !m_halt && !m_rst) && n < 8);
        chk($sformatf("lat_op%0d", op), 32'(n), (op < 3) ? 32'd4 : 32'd2);
    endtask

    initial begin
        int base;
        m_rst = 1; m_halt = 0; m_cyc = 0; m_cnt = 0;
        op_sel = 3'd0;
        rst = 1; co = 3'd0; z = 0; cont = 0;
        @(negedge clk);
        #1;
        // reset held: RST0, then stub, then I0
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("i0_after_rst", 32'({lec, eri, incp, stop}), 32'b1110);
        // opcode sweep with z=0
        for (int op = 0; op < 7; op++) run_instr(3'(op), 1'b0, 1'b0);
        // BZ taken
        run_instr(3'd4, 1'b1, 1'b0);
        // LD with cont held high behaves like cont=0
        run_instr(3'd1, 1'b0, 1'b1);
        // halt then resume
        op_sel = 3'd7;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        base = m_cnt;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("halt_stop", 32'(stop), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("resume_cnt", 32'(ninstr), 32'(base + 1));
        chk("resume_i0", 32'({lec, eri, incp, stop}), 32'b1110);
        // reset in the middle of ADD, during O0
        op_sel = 3'd2;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("add_o0_alu", 32'(alu), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("rst0_ccp", 32'({ccp, era, scp}), 32'b111);
        cycle(1'b0, 1'b0, 1'b0);
        chk("rst_cnt", 32'(ninstr), 32'd0);
        // 17 CLRs wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) run_instr(3'd5, 1'b0, 1'b0);
        chk("wrap4", 32'(nw), 32'd1);
        chk("nowrap16", 32'(ninstr), 32'd17);
        // random streams
        for (int i = 0; i < 600; i++) begin
            if (!m_rst && !m_halt && m_cyc == 0)
                op_sel = 3'($urandom_range(0, 7));
            cycle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simplez_ctrl.md
# simplez_ctrl

Sequencer (control unit) for the Simplez datapath. It takes the opcode held in RI and the accumulator zero flag. It steps a fetch/decode/operand/writeback state machine and drives every microorder the datapath consumes: memory read/write, RA/CP/RI/AC load and output enables, and ALU function. It replaces the stub sequencer inside the top level so that all eight Simplez instructions execute, and it adds halt/resume control and an executed-instruction counter for monitoring on the LEDs.

## Interface
- `CNTW`, 16: width of the executed-instruction counter.
- `clk`  in  1  system clock; all state updates on the falling edge, same as the datapath registers.
- `rst`  in  1  synchronous reset, active-high, sampled on the falling edge of `clk`.
- `co`  in  3  opcode field RI[11:9].
- `z`  in  1  accumulator zero flag (1 when AC == 0), registered in the datapath.
- `cont`  in  1  resume request; honoured only in HALT.
- `lec`, `esc`  out  1 each  memory read enable / memory write enable.
- `era`  out  1  load RA from the internal address bus.
- `incp`, `ecp`, `ccp`, `scp`  out  1 each  CP increment / CP load / CP clear / CP drives the address bus.
- `eri`, `sri`  out  1 each  RI load from busD / RI.CD drives the address bus.
- `eac`, `sac`  out  1 each  AC load from the ALU / AC drives busD.
- `alu`  out  2  ALU function: 00 pass busD, 01 AC+busD, 10 AC−1, 11 zero.
- `stop`  out  1  processor halted.
- `ninstr`  out  CNTW  count of completed instructions, wraps modulo 2^CNTW.

## Operation
- States: RST0, I0, I1, O0, O1, HALT. Microorders are a combinational function of (state, `co`, `z`). Any microorder not listed for a state is 0. `alu` defaults to 00.
- RST0 (entered on `rst`): `ccp`=1, `era`=1, `scp`=1 (CP←0, RA←0). Next state I0.
- I0 (fetch): `lec`, `eri`, `incp`. Next state I1.
- I1 (decode/execute), by `co`:
  - 0 ST, 1 LD, 2 ADD: `sri`, `era` (RA←CD). Next state O0.
  - 3 BR: `sri`, `era`, `ecp` (RA←CD, CP←CD). Next state I0.
  - 4 BZ with `z`=1: same as BR. With `z`=0: `scp`, `era` (RA←CP). Next state I0.
  - 5 CLR: `eac`, `alu`=11, `scp`, `era`. Next state I0.
  - 6 DEC: `eac`, `alu`=10, `scp`, `era`. Next state I0.
  - 7 HALT: `scp`, `era`. Next state HALT.
- O0 (operand), by `co`:
  - ST: `sac`, `esc`.
  - LD: `lec`, `eac`, `alu`=00.
  - ADD: `lec`, `eac`, `alu`=01.
  - Next state O1.
- O1: `scp`, `era` (RA←CP). Next state I0.
- HALT: `stop`=1, no other microorders. If `cont`=1, next state I0; otherwise remain in HALT.
- `co` values reaching O0 other than 0/1/2 cannot occur. If one does, no microorder is asserted and the FSM still proceeds to O1.
- `ninstr` increments by 1 on every transition into I0 from I1, O1, or HALT (the HALT instruction is counted on resume). RST0→I0 does not count.
- `stop` is 0 in every state except HALT.

## Timing
- Reset: `rst` high at a falling edge forces state RST0 and `ninstr`=0 at that edge, regardless of the current state (reset in the middle of O0 aborts the instruction). RST0 always lasts exactly one cycle after `rst` deasserts.
- Instruction latency in cycles from entering I0 to re-entering I0:
  - BR, BZ, CLR, DEC: 2.
  - ST, LD, ADD: 4.
  - HALT: 2 plus the halted time plus 1 for the `cont` edge.
- `z` is sampled combinationally during I1 only. A DEC that zeroes AC is visible to a BZ that follows it, because `z` updates at the end of the DEC cycle.
- `cont` is level-sampled at the falling edge while in HALT. Holding it high resumes once and then continues normally. `cont` is ignored in all other states.
- Outputs may glitch only in the settling window after the falling edge. They are stable before the next falling edge.

## Test plan
- Reset: assert `rst` for 2 cycles mid-ADD (state O0). Required: state RST0 with `ccp`, `era`, `scp` =1 for one cycle after release; then I0 with `lec`=`eri`=`incp`=1; `ninstr`=0; `stop`=0.
- Opcode sweep: drive `co`=0..6 in turn with `z`=0. Required: the I1/O0/O1 microorder sets above; ST/LD/ADD take 4 cycles per I0, the others 2; `alu`=01 on the ADD O0 cycle and 10 on the DEC I1 cycle.
- BZ: `co`=4 with `z`=1 gives `ecp`=`sri`=`era`=1 and `scp`=0. With `z`=0, `scp`=`era`=1 and `ecp`=0.
- Halt/resume: `co`=7, `cont`=0 for 10 cycles. Required: `stop`=1 throughout and all other microorders 0. Pulse `cont` for 1 cycle: I0 on the next cycle and `ninstr` +1.
- Counter wrap: with `CNTW`=4, run 17 CLR instructions after reset. Required: `ninstr` reads 1.
- Ignored `cont`: hold `cont`=1 while executing LD. Required: timing and microorders identical to the `cont`=0 case.
